// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-memory port between the IFU and the LSU.
// One transaction is outstanding at a time: IDLE (grant) -> WAIT (mem_req held
// until mem_ack or timeout) -> RESP (one-cycle strobe to the owner).
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration;
// without it the LSU has fixed priority over the IFU.
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_resp_valid,
  output logic [DW-1:0] ifu_rdata,
  output logic          ifu_err,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic          lsu_we,
  input  logic [2:0]    lsu_ctr,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_wdata,
  output logic          lsu_resp_valid,
  output logic [DW-1:0] lsu_rdata,
  output logic          lsu_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [2:0]    mem_ctr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner_lsu;
  logic          grant_ifu;
  logic          grant_lsu;
  logic          timeout_hit;

`ifdef MEM_ARB_RR_EN
  // rr_lsu=1 means the LSU wins the next tie; reset favours the IFU.
  logic rr_lsu;

  // Tie-break toward whoever was not granted last.
  always_comb begin
    grant_lsu = lsu_req_valid && (!ifu_req_valid || rr_lsu);
    grant_ifu = ifu_req_valid && !grant_lsu;
  end

  // Pointer flips to the other requester on every accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_lsu <= 1'b0;
    end else if (state == IDLE && (grant_ifu || grant_lsu)) begin
      rr_lsu <= grant_ifu;
    end
  end
`else
  // Fixed priority: LSU always beats IFU.
  always_comb begin
    grant_lsu = lsu_req_valid;
    grant_ifu = ifu_req_valid && !lsu_req_valid;
  end
`endif

  assign ifu_req_ready = (state == IDLE) && grant_ifu;
  assign lsu_req_ready = (state == IDLE) && grant_lsu;
  assign timeout_hit   = (cnt == CW'(TIMEOUT - 1));

  // Transaction FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      owner_lsu      <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_ctr        <= 3'b000;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      ifu_err        <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= '0;
      lsu_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (ifu_req_ready) begin
            owner_lsu <= 1'b0;
            mem_addr  <= ifu_addr;
            mem_we    <= 1'b0;
            mem_ctr   <= 3'b010;
            mem_wdata <= '0;
            mem_req   <= 1'b1;
            state     <= WAIT;
          end else if (lsu_req_ready) begin
            owner_lsu <= 1'b1;
            mem_addr  <= lsu_addr;
            mem_we    <= lsu_we;
            mem_ctr   <= lsu_ctr;
            mem_wdata <= lsu_wdata;
            mem_req   <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // Ack is tested first so it wins over a coincident timeout.
          if (mem_ack || timeout_hit) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (owner_lsu) begin
              lsu_resp_valid <= 1'b1;
              lsu_err        <= !mem_ack;
              lsu_rdata      <= !mem_ack ? DW'(32'hDEAD_BEEF) : (mem_we ? '0 : mem_rdata);
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_err        <= !mem_ack;
              ifu_rdata      <= !mem_ack ? DW'(32'hDEAD_BEEF) : mem_rdata;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ifu_resp_valid <= 1'b0;
          lsu_resp_valid <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
